// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: width calculators and default almost-flag levels
// used by the FIFOs on the RFID byte interface and RSA datapath.
package fifo_pkg;

    // Default distance of almost_full below full, and default almost_empty level.
    localparam int DEF_AF_MARGIN = 4;
    localparam int DEF_AE_LEVEL  = 4;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Bits needed to address depth entries (at least one bit).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Storage for the FIFO: one synchronous write port and one asynchronous
// read port. Kept separate so a vendor RAM macro can be dropped in.
module fifo_dpram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Capture the write word on the rising edge.
    // NOTE: the array deliberately has no reset; pointers/count define validity, and a reset here would block RAM inference.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FWFT FIFO: pointers, occupancy count,
// almost-flags, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 1024,
    parameter int AF_LEVEL = DEPTH - DEF_AF_MARGIN,
    parameter int AE_LEVEL = DEF_AE_LEVEL,
    localparam int AW      = ptr_width(DEPTH),
    localparam int CW      = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
    localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_nxt;
    logic          wr_ok;
    logic          rd_ok;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_C) ? '0 : p + AW'(1);
    endfunction

    // Requests are accepted against pre-edge flags; flush blocks both.
    assign wr_ok = wr_en & ~full  & ~flush;
    assign rd_ok = rd_en & ~empty & ~flush;

    // All status flags decode the registered count only.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // Occupancy moves only when exactly one side is accepted.
    // NOTE: default assigned first so every path drives count_nxt and no latch is inferred.
    always_comb begin
        count_nxt = count;
        if (wr_ok && !rd_ok)      count_nxt = count + CW'(1);
        else if (rd_ok && !wr_ok) count_nxt = count - CW'(1);
    end

    // Pointer, count and sticky error registers; flush outranks requests.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
            count     <= count_nxt;
            overflow  <= overflow  | (wr_en & full);
            underflow <= underflow | (rd_en & empty);
        end
    end

    fifo_dpram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (dout)
    );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=6, AF=5, AE=1):
// a hand-computed vector table, directed corner sequences, then random
// traffic compared against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 6;
    localparam int AF    = 5;
    localparam int AE    = 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;

    // Reference model: the FIFO contents as a plain queue plus sticky flags.
    logic [WIDTH-1:0] model_q[$];
    logic             m_ovf;
    logic             m_unf;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model's view of the FIFO.
    task automatic check_model(input string tag);
        int n;
        n = model_q.size();
        check({tag, ".count"},     32'(count),        32'(n));
        check({tag, ".empty"},     32'(empty),        32'(n == 0));
        check({tag, ".full"},      32'(full),         32'(n == DEPTH));
        check({tag, ".afull"},     32'(almost_full),  32'(n >= AF));
        check({tag, ".aempty"},    32'(almost_empty), 32'(n <= AE));
        check({tag, ".overflow"},  32'(overflow),     32'(m_ovf));
        check({tag, ".underflow"}, 32'(underflow),    32'(m_unf));
        if (n != 0) check({tag, ".dout"}, 32'(dout), 32'(model_q[0]));
    endtask

    // Apply one cycle of inputs, advance the model by the FIFO rules, compare.
    task automatic cycle(input logic f, input logic w, input logic r,
                         input logic [WIDTH-1:0] d, input string tag);
        bit was_full, was_empty;
        flush = f; wr_en = w; rd_en = r; din = d;
        @(posedge clk);
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        if (f) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (w && was_full)  m_ovf = 1'b1;
            if (r && was_empty) m_unf = 1'b1;
            if (r && !was_empty) void'(model_q.pop_front());
            if (w && !was_full)  model_q.push_back(d);
        end
        #1;
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        check_model(tag);
    endtask

    task automatic model_reset();
        model_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    typedef struct {
        logic             f;
        logic             w;
        logic             r;
        logic [WIDTH-1:0] d;
        int               exp_count;
        logic             chk_dout;
        logic [WIDTH-1:0] exp_dout;
        logic             exp_empty;
        logic             exp_aempty;
        logic             exp_afull;
        logic             exp_unf;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // Hand-derived expectations (AE=1, AF=5).
        vecs[0] = '{1'b0, 1'b1, 1'b0, 8'h11, 1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h22, 2, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h33, 3, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 8'h00, 2, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 8'h44, 1, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 8'h55, 2, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};

        rst = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        model_reset();
        #12;
        check("rst.count",  32'(count),        32'd0);
        check("rst.empty",  32'(empty),        32'd1);
        check("rst.full",   32'(full),         32'd0);
        check("rst.aempty", 32'(almost_empty), 32'd1);
        check("rst.afull",  32'(almost_full),  32'd0);
        check("rst.ovf",    32'(overflow),     32'd0);
        check("rst.unf",    32'(underflow),    32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Table: basic FWFT ordering, empty simultaneous access, thresholds, flush.
        for (int i = 0; i < 10; i++) begin
            flush = vecs[i].f; wr_en = vecs[i].w; rd_en = vecs[i].r; din = vecs[i].d;
            @(posedge clk);
            #1;
            flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
            check($sformatf("vec%0d.count", i),  32'(count),        32'(vecs[i].exp_count));
            check($sformatf("vec%0d.empty", i),  32'(empty),        32'(vecs[i].exp_empty));
            check($sformatf("vec%0d.aempty", i), 32'(almost_empty), 32'(vecs[i].exp_aempty));
            check($sformatf("vec%0d.afull", i),  32'(almost_full),  32'(vecs[i].exp_afull));
            check($sformatf("vec%0d.unf", i),    32'(underflow),    32'(vecs[i].exp_unf));
            if (vecs[i].chk_dout)
                check($sformatf("vec%0d.dout", i), 32'(dout), 32'(vecs[i].exp_dout));
        end
        model_reset();

        // Fill to full, then a rejected write sets overflow and leaves count at DEPTH.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 8'hA0 + 8'(i), "fill");
        check("fill.full_count", 32'(count), 32'(DEPTH));
        cycle(1'b0, 1'b1, 1'b0, 8'hEE, "overwrite");
        check("overwrite.ovf", 32'(overflow), 32'd1);
        // Simultaneous at full: read wins, count drops to DEPTH-1.
        cycle(1'b0, 1'b1, 1'b1, 8'hEF, "rw_full");
        check("rw_full.count", 32'(count), 32'(DEPTH - 1));
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00, "drain");

        // Wrap: write 6, read 4, write 4, then read all 6 in order.
        cycle(1'b1, 1'b0, 1'b0, 8'h00, "flush0");
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 8'h10 + 8'(i), "wrap_w1");
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00, "wrap_r1");
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 8'h20 + 8'(i), "wrap_w2");
        check("wrap.count", 32'(count), 32'd6);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00, "wrap_r2");

        // Simultaneous at count=3: count holds, order preserved.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'h30 + 8'(i), "mid_w");
        cycle(1'b0, 1'b1, 1'b1, 8'h3F, "mid_rw");
        check("mid_rw.count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00, "mid_r");

        // Flush with wr_en at count=4 and overflow set.
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b0, 8'h40 + 8'(i), "pre_flush_w");
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00, "pre_flush_r");
        check("pre_flush.count", 32'(count), 32'd4);
        cycle(1'b1, 1'b1, 1'b0, 8'h99, "flush_wr");
        check("flush_wr.ovf", 32'(overflow), 32'd0);

        // Asynchronous reset mid-stream, observed before any clock edge.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 8'h50 + 8'(i), "pre_rst");
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("arst.count", 32'(count),        32'd0);
        check("arst.empty", 32'(empty),        32'd1);
        check("arst.unf",   32'(underflow),    32'd0);
        check("arst.aempty", 32'(almost_empty), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // Random traffic against the queue model.
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 99) < 55),
                  ($urandom_range(0, 99) < 50), 8'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
